bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of 4-bit digits; legal range 1..8.
REQ-002 Parameter BCD, default 1; 1 = decimal digits (0..9), 0 = hex digits (0..15).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Clear_b  input  1  reset, synchronous and active-low.
REQ-005 Data_in  input  4*DIGITS  parallel load value; digit 0 in bits [3:0].
REQ-006 Load  input  1  parallel load request.
REQ-007 Count  input  1  count enable.
REQ-008 Up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 Sat  input  1  end mode: 1 = saturate at terminal value, 0 = wrap.
REQ-010 A_count  output  4*DIGITS  registered count value, digit 0 least significant.
REQ-011 C_out  output  1  combinational carry/borrow lookahead for cascading.
REQ-012 Ovf  output  1  registered sticky overflow/underflow flag.
REQ-013 Load_err  output  1  registered one-cycle pulse flagging an illegal BCD load digit.

Function
REQ-014 Each rising CLK edge SHALL apply exactly one action, priority: reset > Load > Count > hold.
REQ-015 When Load=1, A_count SHALL take Data_in next edge, except as modified by REQ-016.
REQ-016 With BCD=1, any loaded digit >9 SHALL be stored as 9, and Load_err SHALL be 1 for the following cycle only.
REQ-017 Load_err SHALL be 0 in every cycle not immediately following such a load.
REQ-018 When Load=0 and Count=1, A_count SHALL change by exactly one count in the Up direction next edge; latency one cycle.
REQ-019 Increment: digit 0 SHALL add 1; a digit at its max (9 if BCD=1, 15 if BCD=0) SHALL become 0 and carry into the next digit.
REQ-020 Decrement: digit 0 SHALL subtract 1; a digit at 0 SHALL become its max and borrow from the next digit.
REQ-021 Terminal value: all digits at max when Up=1; all digits 0 when Up=0.
REQ-022 At terminal value with Count=1, Load=0: Sat=0 SHALL wrap (all-max -> all-0, all-0 -> all-max); Sat=1 SHALL hold A_count unchanged.
REQ-023 Both the wrap and saturate events of REQ-022 SHALL set Ovf=1 next edge.
REQ-024 Ovf SHALL stay 1 until reset or a Load, either of which clears it next edge; a Load coinciding with a terminal event clears it.
REQ-025 C_out SHALL equal Count & ~Load & ~Sat & (A_count == terminal value for current Up), evaluated combinationally in the same cycle.
REQ-026 Up and Sat MAY change every cycle; each edge SHALL use the values sampled at that edge.
REQ-027 With BCD=1, A_count SHALL never hold a digit >9 under any input sequence after reset.
REQ-028 When Load=0 and Count=0, A_count and Ovf SHALL hold.

Reset
REQ-029 Clear_b=0 at a rising edge SHALL set A_count=0, Ovf=0, Load_err=0, overriding Load and Count.
REQ-030 Reset SHALL have no effect between edges; an operation in progress SHALL be discarded at the reset edge.
REQ-031 C_out SHALL follow REQ-025 during reset (combinational on current state and inputs).

Verification (DIGITS=4, BCD=1 unless stated)
REQ-032 Reset, Count=1, Up=1, 12 edges -> A_count=0x0012, Ovf=0, C_out=0 throughout.
REQ-033 Load 0x9998, Count=1, Up=1, Sat=0 -> 0x9999 with C_out=1, next edge 0x0000, Ovf=1.
REQ-034 Load 0x0001, Up=0, Sat=1, 3 edges -> 0x0000 then held at 0x0000, C_out=0, Ovf=1.
REQ-035 Load 0x3A7F -> A_count=0x3979, Load_err pulses 1 for one cycle; BCD=0 same load -> 0x3A7F, Load_err=0.
REQ-036 Load=1 and Count=1 same edge with Data_in=0x0500 -> A_count=0x0500, Ovf cleared; Clear_b=0 with Load=1 -> A_count=0x0000.
REQ-037 Count at 0x0990, Up=1 -> 0x0991; at 0x0999 -> 0x1000; Up=0 at 0x1000 -> 0x0999.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit up/down counter with decimal or hex digits, parallel load,
// saturate/wrap end modes, sticky overflow and a carry lookahead for cascading.
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 4,
  parameter bit          BCD    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  Clear_b,
  input  logic [4*DIGITS-1:0]   Data_in,
  input  logic                  Load,
  input  logic                  Count,
  input  logic                  Up,
  input  logic                  Sat,
  output logic [4*DIGITS-1:0]   A_count,
  output logic                  C_out,
  output logic                  Ovf,
  output logic                  Load_err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam logic [3:0]  DMAX = BCD ? 4'd9 : 4'd15;

  logic [W-1:0] r_count;
  logic         r_ovf;
  logic         r_load_err;

  logic [W-1:0] w_step;
  logic [W-1:0] w_load_val;
  logic         w_load_bad;
  logic         w_term;
  logic         w_all_max;
  logic         w_all_zero;
  logic         w_carry;
  logic [3:0]   w_dig;
  logic [3:0]   w_ldig;

  // Terminal-value detection on the current count
  always_comb begin
    w_all_max  = 1'b1;
    w_all_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_count[4*i +: 4] != DMAX) w_all_max  = 1'b0;
      if (r_count[4*i +: 4] != 4'd0) w_all_zero = 1'b0;
    end
    w_term = Up ? w_all_max : w_all_zero;
  end

  // Ripple one count through the digits; the terminal case wraps naturally
  always_comb begin
    w_step  = r_count;
    w_carry = 1'b1;
    w_dig   = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_dig = r_count[4*i +: 4];
      if (w_carry) begin
        if (Up) begin
          if (w_dig == DMAX) begin
            w_step[4*i +: 4] = 4'd0;
          end else begin
            w_step[4*i +: 4] = w_dig + 4'd1;
            w_carry          = 1'b0;
          end
        end else begin
          if (w_dig == 4'd0) begin
            w_step[4*i +: 4] = DMAX;
          end else begin
            w_step[4*i +: 4] = w_dig - 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  // Clamp illegal decimal digits on load so the count stays valid
  always_comb begin
    w_load_val = Data_in;
    w_load_bad = 1'b0;
    w_ldig     = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_ldig = Data_in[4*i +: 4];
      if (BCD && (w_ldig > 4'd9)) begin
        w_load_val[4*i +: 4] = 4'd9;
        w_load_bad           = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Clear_b) begin
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (Load) begin
        r_count    <= w_load_val;
        r_ovf      <= 1'b0;
        r_load_err <= w_load_bad;
      end else if (Count) begin
        if (!(w_term && Sat)) r_count <= w_step;
        if (w_term)           r_ovf   <= 1'b1;
      end
    end
  end

  assign A_count  = r_count;
  assign Ovf      = r_ovf;
  assign Load_err = r_load_err;
  assign C_out    = Count & ~Load & ~Sat & w_term;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a decimal and a hex instance share
// the same stimulus and are checked against hand-computed values.
module tb_bcd_updown_counter;

  logic        CLK;
  logic        Clear_b;
  logic [15:0] Data_in;
  logic        Load;
  logic        Count;
  logic        Up;
  logic        Sat;

  logic [15:0] d_cnt, h_cnt;
  logic        d_cout, h_cout;
  logic        d_ovf, h_ovf;
  logic        d_lerr, h_lerr;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_updown_counter #(.DIGITS(4), .BCD(1'b1)) u_dec (
    .CLK(CLK), .Clear_b(Clear_b), .Data_in(Data_in), .Load(Load),
    .Count(Count), .Up(Up), .Sat(Sat),
    .A_count(d_cnt), .C_out(d_cout), .Ovf(d_ovf), .Load_err(d_lerr)
  );

  bcd_updown_counter #(.DIGITS(4), .BCD(1'b0)) u_hex (
    .CLK(CLK), .Clear_b(Clear_b), .Data_in(Data_in), .Load(Load),
    .Count(Count), .Up(Up), .Sat(Sat),
    .A_count(h_cnt), .C_out(h_cout), .Ovf(h_ovf), .Load_err(h_lerr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    Load = 1'b1; Count = 1'b0; Data_in = v;
    tick();
    Load = 1'b0;
  endtask

  initial begin
    Clear_b = 1'b0; Data_in = '0; Load = 1'b0; Count = 1'b0; Up = 1'b1; Sat = 1'b0;
    tick();
    chk("rst_cnt",  d_cnt,  32'h0);
    chk("rst_ovf",  d_ovf,  32'h0);
    chk("rst_lerr", d_lerr, 32'h0);
    chk("rst_cout", d_cout, 32'h0);

    // Count up 12 edges from reset
    Clear_b = 1'b1; Count = 1'b1; Up = 1'b1; Sat = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1 chk("up12_cout", d_cout, 32'h0);
      tick();
    end
    chk("up12_cnt",  d_cnt, 32'h0012);
    chk("up12_ovf",  d_ovf, 32'h0);
    chk("up12_hex",  h_cnt, 32'h000C);

    // Wrap from all-nines with carry lookahead
    load(16'h9998);
    chk("ld9998_cnt", d_cnt, 32'h9998);
    chk("ld9998_hlerr", h_lerr, 32'h0);
    Count = 1'b1; Up = 1'b1; Sat = 1'b0;
    #1 chk("c9998_cout", d_cout, 32'h0);
    tick();
    chk("c9999_cnt",  d_cnt,  32'h9999);
    chk("c9999_cout", d_cout, 32'h1);
    chk("c9999_ovf",  d_ovf,  32'h0);
    tick();
    chk("wrap_cnt",  d_cnt,  32'h0000);
    chk("wrap_ovf",  d_ovf,  32'h1);
    chk("wrap_cout", d_cout, 32'h0);
    chk("wrap_hex",  h_cnt,  32'h999A);
    chk("wrap_hovf", h_ovf,  32'h0);
    Count = 1'b0;
    tick();
    chk("hold_cnt", d_cnt, 32'h0000);
    chk("hold_ovf", d_ovf, 32'h1);

    // Count down with saturation at zero
    load(16'h0001);
    chk("ld0001_ovf", d_ovf, 32'h0);
    Count = 1'b1; Up = 1'b0; Sat = 1'b1;
    tick();
    chk("sat1_cnt", d_cnt, 32'h0000);
    chk("sat1_ovf", d_ovf, 32'h0);
    chk("sat_cout", d_cout, 32'h0);
    tick();
    chk("sat2_cnt", d_cnt, 32'h0000);
    chk("sat2_ovf", d_ovf, 32'h1);
    tick();
    chk("sat3_cnt", d_cnt, 32'h0000);
    chk("sat3_ovf", d_ovf, 32'h1);

    // Illegal decimal digits are clamped on load
    load(16'h3A7F);
    chk("ld3a7f_cnt",  d_cnt,  32'h3979);
    chk("ld3a7f_lerr", d_lerr, 32'h1);
    chk("ld3a7f_ovf",  d_ovf,  32'h0);
    chk("ld3a7f_hex",  h_cnt,  32'h3A7F);
    chk("ld3a7f_hle",  h_lerr, 32'h0);
    tick();
    chk("lerr_drop",  d_lerr, 32'h0);
    chk("lerr_hold",  d_cnt,  32'h3979);

    // Saturate at all-nines, then load+count clears Ovf
    load(16'h9999);
    Count = 1'b1; Up = 1'b1; Sat = 1'b1;
    tick();
    chk("satup_cnt", d_cnt, 32'h9999);
    chk("satup_ovf", d_ovf, 32'h1);
    Load = 1'b1; Data_in = 16'h0500;
    #1 chk("ldcnt_cout", d_cout, 32'h0);
    tick();
    chk("ldcnt_cnt", d_cnt, 32'h0500);
    chk("ldcnt_ovf", d_ovf, 32'h0);

    // Reset overrides a load, including an illegal one
    Clear_b = 1'b0; Load = 1'b1; Data_in = 16'h0A00;
    tick();
    chk("rstld_cnt",  d_cnt,  32'h0000);
    chk("rstld_lerr", d_lerr, 32'h0);
    Clear_b = 1'b1; Load = 1'b0;

    // Digit carries and borrows across boundaries
    load(16'h0990);
    Count = 1'b1; Up = 1'b1; Sat = 1'b0;
    tick();
    chk("c0990", d_cnt, 32'h0991);
    load(16'h0999);
    Count = 1'b1; Up = 1'b1;
    tick();
    chk("c0999", d_cnt, 32'h1000);
    Up = 1'b0;
    tick();
    chk("c1000dn", d_cnt, 32'h0999);
    Up = 1'b1;
    tick();
    chk("toggle_up", d_cnt, 32'h1000);

    // Wrap down from zero: decimal to 9999, hex to FFFF
    load(16'h0000);
    Count = 1'b1; Up = 1'b0; Sat = 1'b0;
    #1 chk("dn0_cout", d_cout, 32'h1);
    tick();
    chk("dn0_cnt",  d_cnt, 32'h9999);
    chk("dn0_ovf",  d_ovf, 32'h1);
    chk("dn0_hex",  h_cnt, 32'hFFFF);
    chk("dn0_hovf", h_ovf, 32'h1);

    // Hex wraps up from FFFF; decimal load of FFFF clamps to 9999
    load(16'hFFFF);
    chk("ldffff_cnt", d_cnt, 32'h9999);
    chk("ldffff_hex", h_cnt, 32'hFFFF);
    Count = 1'b1; Up = 1'b1; Sat = 1'b0;
    #1 chk("ffff_hcout", h_cout, 32'h1);
    tick();
    chk("ffffup_cnt", d_cnt, 32'h0000);
    chk("ffffup_hex", h_cnt, 32'h0000);
    chk("ffffup_hovf", h_ovf, 32'h1);

    // C_out stays live during reset
    Clear_b = 1'b0; Count = 1'b0;
    tick();
    Count = 1'b1; Up = 1'b0; Sat = 1'b0;
    #1 chk("rst_cout_live", d_cout, 32'h1);
    tick();
    chk("rst_cnt2", d_cnt, 32'h0000);
    chk("rst_ovf2", d_ovf, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
